// File: rtl/cp0_exception_ctrl_pkg.sv
// cp0_pkg: shared constants for the CP0 exception controller.
// Holds register numbers, ExcCode values, exc_flags bit indices, Status/Cause
// bit positions and the exception priority encoder.
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // exc_flags bit indices
  localparam int F_ADEL_FETCH = 0;
  localparam int F_RI         = 1;
  localparam int F_OV         = 2;
  localparam int F_SYS        = 3;
  localparam int F_BP         = 4;
  localparam int F_ADEL_DATA  = 5;
  localparam int F_ADES       = 6;

  // Status / Cause bit positions
  localparam int ST_BEV   = 22;
  localparam int ST_EXL   = 1;
  localparam int ST_IE    = 0;
  localparam int MASK_LO  = 8;   // IM / IP occupy [15:8]
  localparam int CA_BD    = 31;
  localparam int CA_TI    = 30;
  localparam int CA_CODE  = 2;   // ExcCode occupies [6:2]

  typedef struct packed {
    logic [4:0] code;
    logic       is_addr;   // winner is an address error: capture BadVAddr
  } exc_sel_t;

  // Strict priority: interrupt first, then the synchronous sources in
  // pipeline order of detection.
  function automatic exc_sel_t exc_prio(input logic int_req, input logic [6:0] f);
    exc_sel_t s;
    s = '{code: EXC_INT, is_addr: 1'b0};
    if (int_req)                s = '{code: EXC_INT,  is_addr: 1'b0};
    else if (f[F_ADEL_FETCH])   s = '{code: EXC_ADEL, is_addr: 1'b1};
    else if (f[F_RI])           s = '{code: EXC_RI,   is_addr: 1'b0};
    else if (f[F_OV])           s = '{code: EXC_OV,   is_addr: 1'b0};
    else if (f[F_SYS])          s = '{code: EXC_SYS,  is_addr: 1'b0};
    else if (f[F_BP])           s = '{code: EXC_BP,   is_addr: 1'b0};
    else if (f[F_ADEL_DATA])    s = '{code: EXC_ADEL, is_addr: 1'b1};
    else if (f[F_ADES])         s = '{code: EXC_ADES, is_addr: 1'b1};
    return s;
  endfunction

endpackage

// File: rtl/cp0_exception_ctrl_if.sv
// cp0_exception_ctrl_if: MEM-stage exception, MTC0/MFC0 and interrupt bundle.
// Handshake: exc_valid qualifies every MEM-stage field (pc, bd, badvaddr,
// flags, eret) in the same cycle; there is no ready/backpressure. flush and
// flush_pc answer combinationally in that cycle, and the CP0 state commits on
// the next clk edge. mtc0_en is a single-cycle write strobe; mfc0 is a pure
// combinational read.
interface cp0_exception_ctrl_if #(parameter int NUM_HW_INT = 6);
  logic                  exc_valid;
  logic [31:0]           exc_pc;
  logic                  exc_bd;
  logic [31:0]           exc_badvaddr;
  logic [6:0]            exc_flags;
  logic                  eret;
  logic                  mtc0_en;
  logic [4:0]            mtc0_addr;
  logic [31:0]           mtc0_wdata;
  logic [4:0]            mfc0_addr;
  logic [31:0]           mfc0_rdata;
  logic [NUM_HW_INT-1:0] hw_int;
  logic                  flush;
  logic [31:0]           flush_pc;

  modport master (
    output exc_valid, exc_pc, exc_bd, exc_badvaddr, exc_flags, eret,
           mtc0_en, mtc0_addr, mtc0_wdata, mfc0_addr, hw_int,
    input  mfc0_rdata, flush, flush_pc
  );

  modport slave (
    input  exc_valid, exc_pc, exc_bd, exc_badvaddr, exc_flags, eret,
           mtc0_en, mtc0_addr, mtc0_wdata, mfc0_addr, hw_int,
    output mfc0_rdata, flush, flush_pc
  );
endinterface

// File: rtl/cp0_exception_ctrl_timer.sv
// cp0_timer: Count prescaler, Count, Compare and the sticky timer interrupt TI.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PMAX);

  // Prescaler and Count; a software write to Count restarts the prescaler
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc <= '0;
      count <= '0;
    end else if (wr_count) begin
      presc <= '0;
      count <= wdata;
    end else if (tick) begin
      presc <= '0;
      count <= count + 32'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Compare register and TI; writing Compare wins over a same-cycle match
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compare <= '0;
      ti      <= 1'b0;
    end else if (wr_compare) begin
      compare <= wdata;
      ti      <= 1'b0;
    end else if (count == compare) begin
      ti      <= 1'b1;
    end
  end
endmodule

// File: rtl/cp0_exception_ctrl.sv
// cp0_exception_ctrl: MEM-stage CP0 with Status/Cause/EPC/BadVAddr, interrupt
// and exception prioritisation, flush/redirect generation and MTC0/MFC0.
// Optional feature macro: CP0_INT_SYNC_EN adds a 2-flop synchroniser on hw_int.
module cp0_exception_ctrl
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input logic                 clk,
  input logic                 resetn,
  cp0_exception_ctrl_if.slave bus
);
  logic [7:0]            im;
  logic                  exl, ie, bd;
  logic [1:0]            sw_ip;
  logic [4:0]            exc_code;
  logic [31:0]           epc, badvaddr;
  logic [31:0]           count, compare;
  logic                  ti;
  logic [NUM_HW_INT-1:0] hw_int_s;
  logic [5:0]            hw_pad;
  logic [7:0]            ip;
  logic                  int_req, take_exc, eret_take, mtc0_ok;
  exc_sel_t              sel;
  logic [31:0]           status_val, cause_val;

`ifdef CP0_INT_SYNC_EN
  logic [NUM_HW_INT-1:0] sync1, sync2;

  // Two-flop synchroniser for asynchronous interrupt sources
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.hw_int;
      sync2 <= sync1;
    end
  end
  assign hw_int_s = sync2;
`else
  assign hw_int_s = bus.hw_int;
`endif

  // Spread the configured lines over IP2..IP7; missing lines read as 0
  always_comb begin
    hw_pad = '0;
    hw_pad[NUM_HW_INT-1:0] = hw_int_s;
  end

  assign ip        = {ti | hw_pad[5], hw_pad[4:0], sw_ip};
  assign int_req   = ie & ~exl & (|(ip & im)) & bus.exc_valid;
  assign take_exc  = int_req | (bus.exc_valid & (|bus.exc_flags));
  assign eret_take = bus.exc_valid & bus.eret & ~take_exc;
  assign mtc0_ok   = bus.mtc0_en & ~take_exc;
  assign sel       = exc_prio(int_req, bus.exc_flags);

  assign bus.flush    = take_exc | eret_take;
  assign bus.flush_pc = take_exc ? EXC_VECTOR : epc;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .wr_count   (mtc0_ok && bus.mtc0_addr == REG_COUNT),
    .wr_compare (mtc0_ok && bus.mtc0_addr == REG_COMPARE),
    .wdata      (bus.mtc0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // Assemble the architectural Status and Cause views
  always_comb begin
    status_val                      = '0;
    status_val[ST_BEV]              = 1'b1;
    status_val[MASK_LO+7:MASK_LO]   = im;
    status_val[ST_EXL]              = exl;
    status_val[ST_IE]               = ie;
    cause_val                       = '0;
    cause_val[CA_BD]                = bd;
    cause_val[CA_TI]                = ti;
    cause_val[MASK_LO+7:MASK_LO]    = ip;
    cause_val[CA_CODE+4:CA_CODE]    = exc_code;
  end

  // MFC0 read mux; unimplemented registers read as zero
  always_comb begin
    bus.mfc0_rdata = '0;
    case (bus.mfc0_addr)
      REG_BADVADDR: bus.mfc0_rdata = badvaddr;
      REG_COUNT:    bus.mfc0_rdata = count;
      REG_COMPARE:  bus.mfc0_rdata = compare;
      REG_STATUS:   bus.mfc0_rdata = status_val;
      REG_CAUSE:    bus.mfc0_rdata = cause_val;
      REG_EPC:      bus.mfc0_rdata = epc;
      default:      bus.mfc0_rdata = '0;
    endcase
  end

  // Status/Cause/EPC/BadVAddr: software writes, then exception/ERET updates
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      sw_ip    <= '0;
      exc_code <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      if (mtc0_ok) begin
        case (bus.mtc0_addr)
          REG_STATUS: begin
            im  <= bus.mtc0_wdata[MASK_LO+7:MASK_LO];
            exl <= bus.mtc0_wdata[ST_EXL];
            ie  <= bus.mtc0_wdata[ST_IE];
          end
          REG_CAUSE: sw_ip <= bus.mtc0_wdata[MASK_LO+1:MASK_LO];
          REG_EPC:   epc   <= bus.mtc0_wdata;
          default: ;
        endcase
      end
      if (take_exc) begin
        exc_code <= sel.code;
        exl      <= 1'b1;
        // A nested exception keeps the original return point
        if (!exl) begin
          epc <= bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
          bd  <= bus.exc_bd;
        end
        if (sel.is_addr) badvaddr <= bus.exc_badvaddr;
      end else if (eret_take) begin
        exl <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// tb_cp0_exception_ctrl: table-driven exception vectors plus hand-written
// sequences for timer, nesting, simultaneous events and interrupt masking.
module tb_cp0_exception_ctrl;
  localparam logic [31:0] VEC = 32'hBFC0_0380;
`ifdef CP0_INT_SYNC_EN
  localparam int INT_LAT = 2;
`else
  localparam int INT_LAT = 0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cp0_exception_ctrl_if #(.NUM_HW_INT(6)) bus ();

  cp0_exception_ctrl #(
    .NUM_HW_INT (6),
    .COUNT_DIV  (2),
    .EXC_VECTOR (32'hBFC0_0380)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Scoreboard
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got %h, no expected value queued", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", name, act, e);
      end
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.exc_valid    = 1'b0;
    bus.exc_pc       = '0;
    bus.exc_bd       = 1'b0;
    bus.exc_badvaddr = '0;
    bus.exc_flags    = '0;
    bus.eret         = 1'b0;
    bus.mtc0_en      = 1'b0;
    bus.mtc0_addr    = '0;
    bus.mtc0_wdata   = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.mtc0_en    = 1'b1;
    bus.mtc0_addr  = a;
    bus.mtc0_wdata = d;
    step();
    bus.mtc0_en    = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.mfc0_addr = a;
    #1;
    d = bus.mfc0_rdata;
  endtask

  task automatic chk_reg(input string name, input logic [4:0] a, input logic [31:0] e);
    logic [31:0] d;
    push_exp(e);
    rd(a, d);
    check(name, d);
  endtask

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] e);
    push_exp(e);
    check(name, act);
  endtask

  task automatic drive_exc(input logic [6:0] f, input logic b, input logic [31:0] pc,
                           input logic [31:0] bva);
    bus.exc_valid    = 1'b1;
    bus.exc_flags    = f;
    bus.exc_bd       = b;
    bus.exc_pc       = pc;
    bus.exc_badvaddr = bva;
  endtask

  typedef struct {
    logic [6:0]  flags;
    logic        bd;
    logic [31:0] pc;
    logic [4:0]  code;
    logic        addr;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [31:0] d, bva, m_bva, epc_exp;
    int k;
    bit found;

    idle();
    bus.hw_int    = '0;
    bus.mfc0_addr = '0;
    m_bva         = '0;

    // Reset values, read while reset is held
    repeat (2) @(posedge clk);
    #1;
    chk_reg("rst_status",   5'd12, 32'h0040_0000);
    chk_reg("rst_cause",    5'd13, 32'h0);
    chk_reg("rst_epc",      5'd14, 32'h0);
    chk_reg("rst_badvaddr", 5'd8,  32'h0);
    chk_reg("rst_count",    5'd9,  32'h0);
    chk_reg("rst_compare",  5'd11, 32'h0);
    chk_val("rst_flush", {31'b0, bus.flush}, 32'h0);
    resetn = 1'b1;
    step();

    // Single-exception vectors, each taken with EXL=0 and IE=0
    vt[0]  = '{7'b0000001, 1'b0, 32'h8000_0010, 5'h04, 1'b1};
    vt[1]  = '{7'b0000010, 1'b1, 32'h8000_0024, 5'h0a, 1'b0};
    vt[2]  = '{7'b0000100, 1'b0, 32'h8000_0038, 5'h0c, 1'b0};
    vt[3]  = '{7'b0001000, 1'b1, 32'h8000_004c, 5'h08, 1'b0};
    vt[4]  = '{7'b0010000, 1'b0, 32'h8000_0050, 5'h09, 1'b0};
    vt[5]  = '{7'b0100000, 1'b1, 32'h8000_0064, 5'h04, 1'b1};
    vt[6]  = '{7'b1000000, 1'b0, 32'h8000_0078, 5'h05, 1'b1};
    vt[7]  = '{7'b0000110, 1'b0, 32'h8000_0080, 5'h0a, 1'b0};
    vt[8]  = '{7'b1111110, 1'b1, 32'h8000_0094, 5'h0a, 1'b0};
    vt[9]  = '{7'b1111000, 1'b0, 32'h8000_00a8, 5'h08, 1'b0};
    vt[10] = '{7'b1100000, 1'b1, 32'h8000_00bc, 5'h04, 1'b1};
    vt[11] = '{7'b0000111, 1'b0, 32'h8000_00c0, 5'h04, 1'b1};

    for (int i = 0; i < 12; i++) begin
      wr(5'd12, 32'h0);
      bva = (i == 6) ? 32'h0000_1003 : $urandom;
      drive_exc(vt[i].flags, vt[i].bd, vt[i].pc, bva);
      epc_exp = vt[i].bd ? vt[i].pc - 32'd4 : vt[i].pc;
      @(negedge clk);
      chk_val("tbl_flush", {31'b0, bus.flush}, 32'h1);
      chk_val("tbl_flush_pc", bus.flush_pc, VEC);
      step();
      idle();
      if (vt[i].addr) m_bva = bva;
      rd(5'd13, d);
      chk_val("tbl_exccode", {27'b0, d[6:2]}, {27'b0, vt[i].code});
      chk_val("tbl_bd", {31'b0, d[31]}, {31'b0, vt[i].bd});
      chk_reg("tbl_epc", 5'd14, epc_exp);
      chk_reg("tbl_badvaddr", 5'd8, m_bva);
      chk_reg("tbl_status", 5'd12, 32'h0040_0002);
    end

    // Timer interrupt: Count runs at clk/2 up to Compare=10
    wr(5'd12, 32'h0);
    wr(5'd9, 32'h0);
    wr(5'd11, 32'd10);
    rd(5'd13, d);
    chk_val("tmr_ti_clear0", {31'b0, d[30]}, 32'h0);
    wr(5'd12, 32'h0000_8001);
    drive_exc(7'b0, 1'b0, 32'h8000_1000, 32'h0);
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.flush) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk_val("tmr_flush_seen", {31'b0, found}, 32'h1);
    if (found) begin
      chk_val("tmr_flush_pc", bus.flush_pc, VEC);
      rd(5'd9, d);
      chk_val("tmr_count", d, 32'd10);
      rd(5'd13, d);
      chk_val("tmr_ti_set", {31'b0, d[30]}, 32'h1);
      step();
      idle();
      rd(5'd13, d);
      chk_val("tmr_exccode", {27'b0, d[6:2]}, 32'h0);
      chk_reg("tmr_epc", 5'd14, 32'h8000_1000);
      chk_reg("tmr_status", 5'd12, 32'h0040_8003);
    end
    idle();
    wr(5'd11, 32'h0000_1000);
    rd(5'd13, d);
    chk_val("tmr_ti_clear", {31'b0, d[30]}, 32'h0);

    // Delay slot, nested exception, ERET
    wr(5'd12, 32'h0);
    drive_exc(7'b0001000, 1'b1, 32'h8000_0104, 32'h0);
    @(negedge clk);
    chk_val("ds_flush", {31'b0, bus.flush}, 32'h1);
    step();
    idle();
    chk_reg("ds_epc", 5'd14, 32'h8000_0100);
    rd(5'd13, d);
    chk_val("ds_bd", {31'b0, d[31]}, 32'h1);
    chk_val("ds_code", {27'b0, d[6:2]}, 32'h08);
    drive_exc(7'b0000100, 1'b0, 32'h9000_0000, 32'h0);
    step();
    idle();
    chk_reg("nest_epc", 5'd14, 32'h8000_0100);
    rd(5'd13, d);
    chk_val("nest_bd", {31'b0, d[31]}, 32'h1);
    chk_val("nest_code", {27'b0, d[6:2]}, 32'h0c);
    bus.exc_valid = 1'b1;
    bus.eret      = 1'b1;
    @(negedge clk);
    chk_val("eret_flush", {31'b0, bus.flush}, 32'h1);
    chk_val("eret_flush_pc", bus.flush_pc, 32'h8000_0100);
    step();
    idle();
    chk_reg("eret_status", 5'd12, 32'h0040_0000);

    // MTC0 in the same cycle as an exception is dropped
    drive_exc(7'b0000100, 1'b0, 32'h8000_2000, 32'h0);
    bus.mtc0_en    = 1'b1;
    bus.mtc0_addr  = 5'd12;
    bus.mtc0_wdata = 32'h0000_ff01;
    step();
    idle();
    chk_reg("sim_status", 5'd12, 32'h0040_0002);
    rd(5'd13, d);
    chk_val("sim_code", {27'b0, d[6:2]}, 32'h0c);
    // ERET together with a fault takes the exception
    drive_exc(7'b0000010, 1'b0, 32'h8000_3000, 32'h0);
    bus.eret = 1'b1;
    @(negedge clk);
    chk_val("eret_exc_pc", bus.flush_pc, VEC);
    step();
    idle();
    rd(5'd13, d);
    chk_val("eret_exc_code", {27'b0, d[6:2]}, 32'h0a);
    chk_reg("eret_exc_epc", 5'd14, 32'h8000_2000);
    chk_reg("eret_exc_status", 5'd12, 32'h0040_0002);

    // IE=0 masks a pending IP2
    wr(5'd12, 32'h0000_0400);
    bus.hw_int    = 6'b000001;
    bus.exc_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_val("mask_no_flush", {31'b0, bus.flush}, 32'h0);
      step();
    end
    rd(5'd13, d);
    chk_val("mask_ip2", {31'b0, d[10]}, 32'h1);
    bus.hw_int    = '0;
    bus.exc_valid = 1'b0;
    repeat (3) step();

    // Interrupt latency from a hw_int[0] rise with IE=1
    wr(5'd12, 32'h0000_0401);
    bus.exc_valid = 1'b1;
    bus.exc_pc    = 32'h8000_4000;
    @(negedge clk);
    chk_val("lat_idle", {31'b0, bus.flush}, 32'h0);
    step();
    bus.hw_int = 6'b000001;
    k = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.flush) begin
        k = c;
        break;
      end
      step();
    end
    chk_val("int_latency", k, INT_LAT);
    step();
    idle();
    bus.hw_int = '0;
    rd(5'd13, d);
    chk_val("int_code", {27'b0, d[6:2]}, 32'h0);
    step();

    // Asynchronous reset in the middle of a cycle
    #2;
    resetn = 1'b0;
    #1;
    chk_reg("arst_status", 5'd12, 32'h0040_0000);
    chk_reg("arst_epc",    5'd14, 32'h0);
    chk_reg("arst_count",  5'd9,  32'h0);
    resetn = 1'b1;
    step();

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
